// File: rtl/h_pair_sequencer_pkg.sv
// Shared S3.4 fixed-point constants, H-stage latency default and FSM encoding
// for the Hadamard pair sequencer.
package h_pair_sequencer_pkg;

    localparam int TOTAL_WIDTH   = 8;
    localparam int FRAC_BITS     = 4;
    localparam logic signed [TOTAL_WIDTH-1:0] ONE = 8'sd16;
    localparam int H_LATENCY_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/h_pair_sequencer_if.sv
// Load/start/status, H-stage operand/result and readback bus of the sequencer.
interface h_pair_sequencer_if
    import h_pair_sequencer_pkg::*;
#(
    parameter int NQ = 3,
    parameter int TW = (NQ > 1) ? $clog2(NQ) : 1,
    parameter int W  = TOTAL_WIDTH
);
    logic                ld_en;
    logic [NQ-1:0]       ld_addr;
    logic signed [W-1:0] ld_r, ld_i;
    logic                start;
    logic [TW-1:0]       target;
    logic                busy;
    logic                done;
    logic                op_valid;
    logic signed [W-1:0] alpha_r, alpha_i, beta_r, beta_i;
    logic signed [W-1:0] h_alpha_r, h_alpha_i, h_beta_r, h_beta_i;
    logic [NQ-1:0]       rd_addr;
    logic signed [W-1:0] rd_r, rd_i;

    modport slave (
        input  ld_en, ld_addr, ld_r, ld_i, start, target,
        input  h_alpha_r, h_alpha_i, h_beta_r, h_beta_i, rd_addr,
        output busy, done, op_valid, alpha_r, alpha_i, beta_r, beta_i, rd_r, rd_i
    );

    modport master (
        output ld_en, ld_addr, ld_r, ld_i, start, target,
        output h_alpha_r, h_alpha_i, h_beta_r, h_beta_i, rd_addr,
        input  busy, done, op_valid, alpha_r, alpha_i, beta_r, beta_i, rd_r, rd_i
    );

endinterface

// File: rtl/h_pair_sequencer_pair_delay_line.sv
// Shift register carrying {valid, i0, i1} alongside the H stage so each result
// pair knows where to land.
module pair_delay_line #(
    parameter int DEPTH = 3,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_vld,
    input  logic [AW-1:0]    i_i0,
    input  logic [AW-1:0]    i_i1,
    output logic [DEPTH-1:0] o_vld_vec,
    output logic             o_vld,
    output logic [AW-1:0]    o_i0,
    output logic [AW-1:0]    o_i1
);
    logic [DEPTH-1:0] r_vld;
    logic [AW-1:0]    r_i0 [DEPTH];
    logic [AW-1:0]    r_i1 [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_i0[k] <= '0;
                r_i1[k] <= '0;
            end
        end else begin
            r_vld[0] <= i_vld;
            r_i0[0]  <= i_i0;
            r_i1[0]  <= i_i1;
            for (int k = 1; k < DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_i0[k]  <= r_i0[k-1];
                r_i1[k]  <= r_i1[k-1];
            end
        end
    end

    assign o_vld_vec = r_vld;
    assign o_vld     = r_vld[DEPTH-1];
    assign o_i0      = r_i0[DEPTH-1];
    assign o_i1      = r_i1[DEPTH-1];

endmodule

// File: rtl/h_pair_sequencer.sv
// Streams every (i, i | 1<<target) amplitude pair into the pipelined H stage
// and writes the returned pair back in place, one pair per cycle.
module h_pair_sequencer
    import h_pair_sequencer_pkg::*;
#(
    parameter int NQ        = 3,
    parameter int H_LATENCY = H_LATENCY_DEF,
    parameter int TW        = (NQ > 1) ? $clog2(NQ) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    h_pair_sequencer_if.slave io
);
    localparam int N     = 1 << NQ;
    localparam int NP    = N / 2;
    localparam int JW    = (NQ > 1) ? NQ - 1 : 1;
    localparam int DEPTH = H_LATENCY + 1;
    localparam int W     = TOTAL_WIDTH;

    // Pair j -> i0: j with a zero bit spliced in at the target position.
    function automatic logic [NQ-1:0] insert_zero(input logic [JW-1:0] j, input logic [TW-1:0] t);
        logic [NQ-1:0] jj;
        logic [NQ-1:0] mask;
        jj   = NQ'(j);
        mask = (NQ'(1) << t) - NQ'(1);
        return ((jj & ~mask) << 1) | (jj & mask);
    endfunction

    seq_state_t          r_state, w_state_nxt;
    logic [JW-1:0]       r_j;
    logic [TW-1:0]       r_target;
    logic signed [W-1:0] r_mem_r [N];
    logic signed [W-1:0] r_mem_i [N];
    logic signed [W-1:0] r_alpha_r_p1, r_alpha_i_p1, r_beta_r_p1, r_beta_i_p1;
    logic                r_vld_p1;
    logic signed [W-1:0] r_rd_r, r_rd_i;

    logic [NQ-1:0]       w_i0, w_i1;
    logic                w_start_ok, w_load_ok, w_issue, w_busy, w_done, w_pending;
    logic [DEPTH-1:0]    w_dl_vld_vec;
    logic                w_wb_vld;
    logic [NQ-1:0]       w_wb_i0, w_wb_i1;

    assign w_start_ok = (r_state == ST_IDLE) && io.start && (int'(io.target) < NQ);
    assign w_load_ok  = (r_state == ST_IDLE) && io.ld_en;
    assign w_i0       = insert_zero(r_j, r_target);
    assign w_i1       = w_i0 | (NQ'(1) << r_target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok) w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (r_j == JW'(NP - 1)) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!w_pending) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_issue = (r_state == ST_ISSUE);
        w_busy  = (r_state != ST_IDLE);
        w_done  = (r_state == ST_DONE);
    end

    // Nothing is pushed while draining, so once only the output stage holds a
    // live pair, the line is empty after this edge's write-back.
    always_comb begin
        w_pending = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) w_pending = w_pending | w_dl_vld_vec[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_j      <= '0;
            r_target <= '0;
        end else begin
            if (w_start_ok) r_target <= io.target;
            if (w_issue && r_j != JW'(NP - 1)) r_j <= r_j + JW'(1);
            else                               r_j <= '0;
        end
    end

    // --- stage p1: operand registers toward the H stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1     <= 1'b0;
            r_alpha_r_p1 <= '0;
            r_alpha_i_p1 <= '0;
            r_beta_r_p1  <= '0;
            r_beta_i_p1  <= '0;
        end else if (w_issue) begin
            r_vld_p1     <= 1'b1;
            r_alpha_r_p1 <= r_mem_r[w_i0];
            r_alpha_i_p1 <= r_mem_i[w_i0];
            r_beta_r_p1  <= r_mem_r[w_i1];
            r_beta_i_p1  <= r_mem_i[w_i1];
        end else begin
            r_vld_p1     <= 1'b0;
            r_alpha_r_p1 <= '0;
            r_alpha_i_p1 <= '0;
            r_beta_r_p1  <= '0;
            r_beta_i_p1  <= '0;
        end
    end

    pair_delay_line #(
        .DEPTH (DEPTH),
        .AW    (NQ)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_vld     (w_issue),
        .i_i0      (w_i0),
        .i_i1      (w_i1),
        .o_vld_vec (w_dl_vld_vec),
        .o_vld     (w_wb_vld),
        .o_i0      (w_wb_i0),
        .o_i1      (w_wb_i1)
    );

    // Loads only happen in IDLE and write-backs only while busy, so the two
    // write ports never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                r_mem_r[k] <= '0;
                r_mem_i[k] <= '0;
            end
        end else begin
            if (w_load_ok) begin
                r_mem_r[io.ld_addr] <= io.ld_r;
                r_mem_i[io.ld_addr] <= io.ld_i;
            end
            if (w_wb_vld) begin
                r_mem_r[w_wb_i0] <= io.h_alpha_r;
                r_mem_i[w_wb_i0] <= io.h_alpha_i;
                r_mem_r[w_wb_i1] <= io.h_beta_r;
                r_mem_i[w_wb_i1] <= io.h_beta_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_r <= '0;
            r_rd_i <= '0;
        end else begin
            r_rd_r <= r_mem_r[io.rd_addr];
            r_rd_i <= r_mem_i[io.rd_addr];
        end
    end

    assign io.busy     = w_busy;
    assign io.done     = w_done;
    assign io.op_valid = r_vld_p1;
    assign io.alpha_r  = r_alpha_r_p1;
    assign io.alpha_i  = r_alpha_i_p1;
    assign io.beta_r   = r_beta_r_p1;
    assign io.beta_i   = r_beta_i_p1;
    assign io.rd_r     = r_rd_r;
    assign io.rd_i     = r_rd_i;

endmodule

// File: tb/tb_h_pair_sequencer.sv
// Directed bench for h_pair_sequencer with a two-cycle S3.4 Hadamard stage model.
module tb_h_pair_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    h_pair_sequencer_if #(.NQ(3)) io ();

    h_pair_sequencer #(.NQ(3), .H_LATENCY(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    // Hadamard stage: (a+b)/sqrt2, (a-b)/sqrt2 with 1/sqrt2 ~ 181/256, rounded.
    function automatic logic signed [7:0] hs(input int x);
        int y;
        y = (x * 181 + 128) >>> 8;
        return y[7:0];
    endfunction

    logic signed [7:0] s1_ar, s1_ai, s1_br, s1_bi, s2_ar, s2_ai, s2_br, s2_bi;
    always @(posedge clk) begin
        s1_ar <= hs(int'(io.alpha_r) + int'(io.beta_r));
        s1_ai <= hs(int'(io.alpha_i) + int'(io.beta_i));
        s1_br <= hs(int'(io.alpha_r) - int'(io.beta_r));
        s1_bi <= hs(int'(io.alpha_i) - int'(io.beta_i));
        s2_ar <= s1_ar;
        s2_ai <= s1_ai;
        s2_br <= s1_br;
        s2_bi <= s1_bi;
    end
    assign io.h_alpha_r = s2_ar;
    assign io.h_alpha_i = s2_ai;
    assign io.h_beta_r  = s2_br;
    assign io.h_beta_i  = s2_bi;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int addr, input int vr, input int vi);
        io.ld_en   = 1'b1;
        io.ld_addr = addr[2:0];
        io.ld_r    = vr[7:0];
        io.ld_i    = vi[7:0];
        tick();
        io.ld_en   = 1'b0;
    endtask

    task automatic readchk(input string tag, input int addr, input int er, input int ei);
        io.rd_addr = addr[2:0];
        tick();
        chk({tag, "_r"}, io.rd_r, er);
        chk({tag, "_i"}, io.rd_i, ei);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // start (and optionally ld_en) already driven; returns cycles until done
    task automatic wait_done(input int poke, output int len);
        int n;
        tick();
        io.start = 1'b0;
        io.ld_en = 1'b0;
        n = 1;
        chk("busy_after_start", io.busy, 1);
        while (!io.done && n < 60) begin
            if (n == poke) begin
                io.start   = 1'b1;
                io.target  = 2'd0;
                io.ld_en   = 1'b1;
                io.ld_addr = 3'd2;
                io.ld_r    = 8'sd55;
                io.ld_i    = 8'sd55;
            end
            tick();
            io.start = 1'b0;
            io.ld_en = 1'b0;
            n++;
        end
        len = n;
        tick();
        chk("done_one_cycle", io.done, 0);
        chk("idle_after_done", io.busy, 0);
    endtask

    task automatic run_pass(input int tgt, input int poke, output int len);
        io.start  = 1'b1;
        io.target = tgt[1:0];
        wait_done(poke, len);
    endtask

    initial begin
        int len;
        int nrec;
        int ca[4];
        int cb[4];
        int cc[4];
        logic seen;

        io.ld_en = 0; io.ld_addr = 0; io.ld_r = 0; io.ld_i = 0;
        io.start = 0; io.target = 0; io.rd_addr = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", io.busy, 0);
        chk("rst_done", io.done, 0);
        chk("rst_op_valid", io.op_valid, 0);
        chk("rst_alpha_r", io.alpha_r, 0);
        chk("rst_rd_r", io.rd_r, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        tick();

        // basis state |000>, target 0
        load(0, 16, 0);
        run_pass(0, -1, len);
        chk("basis_len", len, 8);
        readchk("basis_m0", 0, 11, 0);
        readchk("basis_m1", 1, 11, 0);
        for (int a = 2; a < 8; a++) readchk("basis_rest", a, 0, 0);

        // |001>, target 0
        do_reset();
        tick();
        load(1, 16, 0);
        run_pass(0, -1, len);
        chk("b001_len", len, 8);
        readchk("b001_m0", 0, 11, 0);
        readchk("b001_m1", 1, -11, 0);

        // ordering with mem[i]=i, target 2
        do_reset();
        tick();
        for (int a = 0; a < 8; a++) load(a, a, 0);
        io.start  = 1'b1;
        io.target = 2'd2;
        tick();
        io.start  = 1'b0;
        nrec = 0;
        for (int c = 1; c <= 12; c++) begin
            if (io.op_valid) begin
                if (nrec < 4) begin
                    ca[nrec] = io.alpha_r;
                    cb[nrec] = io.beta_r;
                    cc[nrec] = c;
                end
                nrec++;
            end
            if (c == 6) chk("op_zero_when_invalid", io.beta_r, 0);
            tick();
        end
        chk("order_count", nrec, 4);
        for (int k = 0; k < 4; k++) begin
            chk("order_alpha", ca[k], k);
            chk("order_beta", cb[k], k + 4);
            chk("order_cycle", cc[k], k + 2);
        end
        readchk("order_m0", 0, 3, 0);
        readchk("order_m4", 4, -3, 0);
        readchk("order_m3", 3, 7, 0);
        readchk("order_m7", 7, -3, 0);

        // illegal target: ignored
        io.start  = 1'b1;
        io.target = 2'd3;
        tick();
        io.start  = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            seen = seen | io.busy | io.done;
            tick();
        end
        chk("illegal_target_ignored", seen, 0);

        // start and ld_en while busy: ignored
        do_reset();
        tick();
        load(0, 16, 0);
        run_pass(0, 3, len);
        chk("busy_poke_len", len, 8);
        chk("no_restart", io.busy, 0);
        readchk("busy_ld_m2", 2, 0, 0);
        readchk("busy_poke_m0", 0, 11, 0);
        readchk("busy_poke_m1", 1, 11, 0);

        // reset in the middle of ISSUE
        load(5, 9, 0);
        io.start  = 1'b1;
        io.target = 2'd0;
        tick();
        io.start  = 1'b0;
        tick();
        chk("pre_rst_op_valid", io.op_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", io.busy, 0);
        chk("midrst_op_valid", io.op_valid, 0);
        chk("midrst_alpha_r", io.alpha_r, 0);
        chk("midrst_beta_r", io.beta_r, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int a = 0; a < 8; a++) readchk("midrst_mem", a, 0, 0);

        // load and start in the same cycle
        io.ld_en   = 1'b1;
        io.ld_addr = 3'd0;
        io.ld_r    = 8'sd16;
        io.ld_i    = 8'sd0;
        io.start   = 1'b1;
        io.target  = 2'd0;
        wait_done(-1, len);
        chk("ldstart_len", len, 8);
        readchk("ldstart_m0", 0, 11, 0);
        readchk("ldstart_m1", 1, 11, 0);
        readchk("ldstart_m2", 2, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/h_pair_sequencer.md
# h_pair_sequencer

Upstream operand sequencer for the pipelined Hadamard stage of the QFT datapath. Holds a 2^NQ-entry complex state vector in S3.4 fixed point. On `start` it streams every amplitude pair (i, i | 1<<target) into `h_gate_pipelined`, one pair per cycle. It then writes the returned pair back in place once the H-stage latency has elapsed, so the in-place H application of one QFT layer is complete when `done` pulses.

## Interface
Parameters:
- NQ, default 3: number of qubits; the state vector has N = 2^NQ amplitudes.
- H_LATENCY, default 2: clock cycles from operands presented to the H stage until its results are valid.
- TW, default $clog2(NQ) (min 1): width of the target-qubit field.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- ld_en  in  1  write one amplitude (IDLE only).
- ld_addr  in  NQ  amplitude index for the load.
- ld_r, ld_i  in  TOTAL_WIDTH each  amplitude to load, S3.4 signed.
- start  in  1  begin one H pass.
- target  in  TW  target qubit, sampled with `start`.
- busy  out  1  high from the cycle after an accepted start until `done`, inclusive.
- done  out  1  one-cycle pulse when the last write-back has landed.
- op_valid  out  1  alpha/beta outputs carry a live pair this cycle.
- alpha_r, alpha_i, beta_r, beta_i  out  TOTAL_WIDTH each  operands to the H stage; registered.
- h_alpha_r, h_alpha_i, h_beta_r, h_beta_i  in  TOTAL_WIDTH each  results from the H stage.
- rd_addr  in  NQ  readback index.
- rd_r, rd_i  out  TOTAL_WIDTH each  registered readback, valid 1 cycle after `rd_addr`.

## Operation
- State machine:
  - IDLE --(start & target<NQ)--> ISSUE --(pair counter j reaches N/2-1)--> DRAIN --(delay line empty)--> DONE --> IDLE.
  - DONE lasts exactly one cycle and drives `done`=1.
- Pair generation: j counts 0..N/2-1. i0 is j with a 0 bit inserted at position `target`; i1 = i0 | (1<<target).
  - Example, NQ=3, target=1: (0,2), (1,3), (4,6), (5,7).
- ISSUE cycle j reads mem[i0] and mem[i1] into the operand registers and sets op_valid for the following cycle.
- {i0, i1, valid} enter a delay line of depth H_LATENCY+1. When the valid bit exits, h_alpha is written to mem[i0] and h_beta to mem[i1] in the same cycle.
- Pairs within one pass are disjoint, so a write-back never aliases a pending read. No forwarding is required.
- Operand outputs are driven to 0 whenever op_valid=0.
- Widths: storage, operands and results are TOTAL_WIDTH. No saturation or rounding is applied here; the H stage owns the arithmetic.
- Boundary conditions:
  - `start` with target >= NQ: ignored; stays IDLE, no done.
  - `start` or `ld_en` while busy: ignored.
  - `ld_en` and `start` in the same IDLE cycle: the load is written and the start is accepted; the first read sees the loaded value.
  - Readback is legal at any time; during a pass it returns the current, partially updated contents.

## Timing
- Reset (asynchronous, immediate): state IDLE; all N amplitudes = 0; j = 0; delay line cleared; busy, done and op_valid = 0; all operand outputs and rd_r/rd_i = 0.
- Reset mid-pass aborts the pass; the state vector is lost (zeroed).
- Start accepted at edge t0:
  - ISSUE occupies cycles t0+1 .. t0+N/2.
  - op_valid is high on cycles t0+2 .. t0+N/2+1.
  - The write-back of pair j lands at edge t0+j+2+H_LATENCY.
  - done is high in the cycle after the last write-back.
- Total busy length = N/2 + H_LATENCY + 2 cycles. Throughput is one pair per cycle, with no bubbles.

## Structure
- Shared header (alongside `fixed_point_params.vh`): TOTAL_WIDTH, the S3.4 constant ONE (16), state encoding localparams, and the default H_LATENCY matching `h_gate_pipelined`.
- One natural sub-module: `pair_delay_line`, a parameterised depth × {valid, i0, i1} shift register with async active-low clear.
- Index insertion is a local function inside `h_pair_sequencer`.

## Test plan
- Reset mid-ISSUE: assert rst_n=0 → busy, op_valid and outputs are 0 immediately; all readbacks return 0; a following start runs normally.
- Basis state |000>: mem[0]=16, others 0; start with target=0, chained to `h_gate_pipelined` → mem[0]=11, mem[1]=11, others 0; done pulses exactly N/2+H_LATENCY+2 = 8 cycles after start.
- |001>: mem[1]=16; target=0 → mem[0]=11, mem[1]=-11.
- Ordering, NQ=3, target=2, mem[i]=i (real): op_valid pairs are (0,4), (1,5), (2,6), (3,7) on consecutive cycles with no gaps.
- Illegal and ignored starts:
  - start with target=3 (NQ=3) → no busy, no done.
  - start while busy → the pass length is unchanged.
  - ld_en while busy → the memory is unchanged.
- Load and start in the same cycle: ld_addr=0, value 16, together with start, target=0 → same result as the basis-state scenario.
